// File: rtl/axi4_lite_addr_decoder_if.sv
// AXI4-Lite channel bundle (with rlast) used by the upstream master and each downstream port.
interface axi4_if #(
  parameter int unsigned A = 32,
  parameter int unsigned N = 4,
  parameter int unsigned I = 1
);
  logic           awvalid, awready;
  logic [A-1:0]   awaddr;
  logic [I-1:0]   awid;
  logic [2:0]     awprot;
  logic           wvalid, wready;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           bvalid, bready;
  logic [1:0]     bresp;
  logic [I-1:0]   bid;
  logic           arvalid, arready;
  logic [A-1:0]   araddr;
  logic [I-1:0]   arid;
  logic [2:0]     arprot;
  logic           rvalid, rready;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic [I-1:0]   rid;
  logic           rlast;

  modport slave (
    input  awvalid, awaddr, awid, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arid, arprot, rready,
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
  );
  modport master (
    output awvalid, awaddr, awid, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arid, arprot, rready,
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
  );
endinterface

// File: rtl/axi4_lite_addr_decoder.sv
// Single-outstanding AXI4-Lite address decoder: routes each write/read to region 0, region 1
// or the default slave, with independent write and read FSMs.
module axi4_lite_addr_decoder #(
  parameter int unsigned A     = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned I     = 1,
  parameter logic [A-1:0] BASE0 = A'(32'h0000_0000),
  parameter logic [A-1:0] MASK0 = A'(32'hFFFF_F000),
  parameter logic [A-1:0] BASE1 = A'(32'h0000_1000),
  parameter logic [A-1:0] MASK1 = A'(32'hFFFF_F000)
) (
  input  logic   aclk,
  input  logic   aresetn,
  axi4_if.slave  axi4_m,
  axi4_if.master axi4_s0,
  axi4_if.master axi4_s1,
  axi4_if.master axi4_def
);
  localparam int unsigned DW = 8 * N;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP} r_state_e;
  typedef enum logic [1:0] {TGT_DEF, TGT_S0, TGT_S1} tgt_e;

  w_state_e       w_state_q, w_state_d;
  r_state_e       r_state_q, r_state_d;
  tgt_e           wtgt_q, wtgt_d, rtgt_q, rtgt_d;
  logic [A-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [I-1:0]   awid_q, awid_d, arid_q, arid_d;
  logic [2:0]     awprot_q, awprot_d, arprot_q, arprot_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [N-1:0]   wstrb_q, wstrb_d;
  logic           aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic           t_awready, t_wready, t_bvalid, t_arready, t_rvalid;
  logic [1:0]     t_bresp, t_rresp;
  logic [I-1:0]   t_bid, t_rid;
  logic [DW-1:0]  t_rdata;

  logic           m_awready_c, m_arready_c, m_bvalid_c, m_rvalid_c;
  logic [2:0]     wsel, rsel, s_awvalid_c, s_wvalid_c, s_bready_c, s_arvalid_c, s_rready_c;

  // Region 0 wins over region 1; anything else goes to the default slave.
  function automatic tgt_e decode(input logic [A-1:0] addr);
    if ((addr & MASK0) == BASE0) return TGT_S0;
    if ((addr & MASK1) == BASE1) return TGT_S1;
    return TGT_DEF;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wtgt_q    <= TGT_DEF;
      rtgt_q    <= TGT_DEF;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      awid_q    <= '0;
      arid_q    <= '0;
      awprot_q  <= '0;
      arprot_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wtgt_q    <= wtgt_d;
      rtgt_q    <= rtgt_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      awid_q    <= awid_d;
      arid_q    <= arid_d;
      awprot_q  <= awprot_d;
      arprot_q  <= arprot_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Only the latched target's responses are visible; the other ports are ignored.
  always_comb begin
    t_awready = axi4_def.awready; t_wready = axi4_def.wready;
    t_bvalid  = axi4_def.bvalid;  t_bresp  = axi4_def.bresp;  t_bid = axi4_def.bid;
    t_arready = axi4_def.arready; t_rvalid = axi4_def.rvalid;
    t_rdata   = axi4_def.rdata;   t_rresp  = axi4_def.rresp;  t_rid = axi4_def.rid;
    case (wtgt_q)
      TGT_S0: begin
        t_awready = axi4_s0.awready; t_wready = axi4_s0.wready;
        t_bvalid  = axi4_s0.bvalid;  t_bresp  = axi4_s0.bresp; t_bid = axi4_s0.bid;
      end
      TGT_S1: begin
        t_awready = axi4_s1.awready; t_wready = axi4_s1.wready;
        t_bvalid  = axi4_s1.bvalid;  t_bresp  = axi4_s1.bresp; t_bid = axi4_s1.bid;
      end
      default: ;
    endcase
    case (rtgt_q)
      TGT_S0: begin
        t_arready = axi4_s0.arready; t_rvalid = axi4_s0.rvalid;
        t_rdata   = axi4_s0.rdata;   t_rresp  = axi4_s0.rresp; t_rid = axi4_s0.rid;
      end
      TGT_S1: begin
        t_arready = axi4_s1.arready; t_rvalid = axi4_s1.rvalid;
        t_rdata   = axi4_s1.rdata;   t_rresp  = axi4_s1.rresp; t_rid = axi4_s1.rid;
      end
      default: ;
    endcase
  end

  // Write next-state: AW and W are accepted together, then forwarded with separate done flags.
  always_comb begin
    w_state_d = w_state_q;
    wtgt_d    = wtgt_q;
    awaddr_d  = awaddr_q;
    awid_d    = awid_q;
    awprot_d  = awprot_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: if (axi4_m.awvalid && axi4_m.wvalid) begin
        awaddr_d  = axi4_m.awaddr;
        awid_d    = axi4_m.awid;
        awprot_d  = axi4_m.awprot;
        wdata_d   = axi4_m.wdata;
        wstrb_d   = axi4_m.wstrb;
        wtgt_d    = decode(axi4_m.awaddr);
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        w_state_d = W_FWD;
      end
      W_FWD: begin
        aw_done_d = aw_done_q | t_awready;
        w_done_d  = w_done_q | t_wready;
        if (aw_done_d && w_done_d) w_state_d = W_RESP;
      end
      W_RESP: if (t_bvalid && axi4_m.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rtgt_d    = rtgt_q;
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    arprot_d  = arprot_q;
    case (r_state_q)
      R_IDLE: if (axi4_m.arvalid) begin
        araddr_d  = axi4_m.araddr;
        arid_d    = axi4_m.arid;
        arprot_d  = axi4_m.arprot;
        rtgt_d    = decode(axi4_m.araddr);
        r_state_d = R_FWD;
      end
      R_FWD:  if (t_arready) r_state_d = R_RESP;
      R_RESP: if (t_rvalid && axi4_m.rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Output decode; one-hot select vectors are ordered {s1, s0, def}.
  always_comb begin
    wsel        = {wtgt_q == TGT_S1, wtgt_q == TGT_S0, wtgt_q == TGT_DEF};
    rsel        = {rtgt_q == TGT_S1, rtgt_q == TGT_S0, rtgt_q == TGT_DEF};
    m_awready_c = aresetn && (w_state_q == W_IDLE) && axi4_m.awvalid && axi4_m.wvalid;
    m_arready_c = aresetn && (r_state_q == R_IDLE) && axi4_m.arvalid;
    m_bvalid_c  = (w_state_q == W_RESP) && t_bvalid;
    m_rvalid_c  = (r_state_q == R_RESP) && t_rvalid;
    s_awvalid_c = {3{(w_state_q == W_FWD) && !aw_done_q}} & wsel;
    s_wvalid_c  = {3{(w_state_q == W_FWD) && !w_done_q}} & wsel;
    s_bready_c  = {3{(w_state_q == W_RESP) && axi4_m.bready}} & wsel;
    s_arvalid_c = {3{r_state_q == R_FWD}} & rsel;
    s_rready_c  = {3{(r_state_q == R_RESP) && axi4_m.rready}} & rsel;
  end

  assign axi4_m.awready = m_awready_c;
  assign axi4_m.wready  = m_awready_c;
  assign axi4_m.bvalid  = m_bvalid_c;
  assign axi4_m.bresp   = t_bresp;
  assign axi4_m.bid     = t_bid;
  assign axi4_m.arready = m_arready_c;
  assign axi4_m.rvalid  = m_rvalid_c;
  assign axi4_m.rdata   = t_rdata;
  assign axi4_m.rresp   = t_rresp;
  assign axi4_m.rid     = t_rid;
  assign axi4_m.rlast   = 1'b1;

  assign axi4_def.awvalid = s_awvalid_c[0];
  assign axi4_def.wvalid  = s_wvalid_c[0];
  assign axi4_def.bready  = s_bready_c[0];
  assign axi4_def.arvalid = s_arvalid_c[0];
  assign axi4_def.rready  = s_rready_c[0];
  assign axi4_def.awaddr  = awaddr_q;
  assign axi4_def.awid    = awid_q;
  assign axi4_def.awprot  = awprot_q;
  assign axi4_def.wdata   = wdata_q;
  assign axi4_def.wstrb   = wstrb_q;
  assign axi4_def.araddr  = araddr_q;
  assign axi4_def.arid    = arid_q;
  assign axi4_def.arprot  = arprot_q;

  assign axi4_s0.awvalid = s_awvalid_c[1];
  assign axi4_s0.wvalid  = s_wvalid_c[1];
  assign axi4_s0.bready  = s_bready_c[1];
  assign axi4_s0.arvalid = s_arvalid_c[1];
  assign axi4_s0.rready  = s_rready_c[1];
  assign axi4_s0.awaddr  = awaddr_q;
  assign axi4_s0.awid    = awid_q;
  assign axi4_s0.awprot  = awprot_q;
  assign axi4_s0.wdata   = wdata_q;
  assign axi4_s0.wstrb   = wstrb_q;
  assign axi4_s0.araddr  = araddr_q;
  assign axi4_s0.arid    = arid_q;
  assign axi4_s0.arprot  = arprot_q;

  assign axi4_s1.awvalid = s_awvalid_c[2];
  assign axi4_s1.wvalid  = s_wvalid_c[2];
  assign axi4_s1.bready  = s_bready_c[2];
  assign axi4_s1.arvalid = s_arvalid_c[2];
  assign axi4_s1.rready  = s_rready_c[2];
  assign axi4_s1.awaddr  = awaddr_q;
  assign axi4_s1.awid    = awid_q;
  assign axi4_s1.awprot  = awprot_q;
  assign axi4_s1.wdata   = wdata_q;
  assign axi4_s1.wstrb   = wstrb_q;
  assign axi4_s1.araddr  = araddr_q;
  assign axi4_s1.arid    = arid_q;
  assign axi4_s1.arprot  = arprot_q;
endmodule

// File: tb/tb_axi4_lite_addr_decoder.sv
// Directed bench for axi4_lite_addr_decoder: routing, back-pressure, concurrency and reset.
module tb_axi4_lite_addr_decoder;
  logic aclk = 1'b0;
  logic aresetn;
  int   checks = 0;
  int   errors = 0;

  always #5 aclk = ~aclk;

  axi4_if #(.A(32), .N(4), .I(1)) m_if ();
  axi4_if #(.A(32), .N(4), .I(1)) s0_if ();
  axi4_if #(.A(32), .N(4), .I(1)) s1_if ();
  axi4_if #(.A(32), .N(4), .I(1)) def_if ();

  axi4_lite_addr_decoder #(.A(32), .N(4), .I(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axi4_m(m_if), .axi4_s0(s0_if), .axi4_s1(s1_if), .axi4_def(def_if)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    m_if.awvalid = 0; m_if.awaddr = 0; m_if.awid = 0; m_if.awprot = 0;
    m_if.wvalid = 0; m_if.wdata = 0; m_if.wstrb = 0; m_if.bready = 0;
    m_if.arvalid = 0; m_if.araddr = 0; m_if.arid = 0; m_if.arprot = 0; m_if.rready = 0;
    s0_if.awready = 0; s0_if.wready = 0; s0_if.bvalid = 0; s0_if.bresp = 0; s0_if.bid = 0;
    s0_if.arready = 0; s0_if.rvalid = 0; s0_if.rdata = 0; s0_if.rresp = 0; s0_if.rid = 0; s0_if.rlast = 0;
    s1_if.awready = 0; s1_if.wready = 0; s1_if.bvalid = 0; s1_if.bresp = 0; s1_if.bid = 0;
    s1_if.arready = 0; s1_if.rvalid = 0; s1_if.rdata = 0; s1_if.rresp = 0; s1_if.rid = 0; s1_if.rlast = 0;
    def_if.awready = 0; def_if.wready = 0; def_if.bvalid = 0; def_if.bresp = 0; def_if.bid = 0;
    def_if.arready = 0; def_if.rvalid = 0; def_if.rdata = 0; def_if.rresp = 0; def_if.rid = 0; def_if.rlast = 0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    idle_inputs();
    m_if.awvalid = 1; m_if.wvalid = 1; m_if.arvalid = 1;
    step();
    checks++; if (m_if.awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %0b exp 0", m_if.awready); end
    checks++; if (m_if.arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %0b exp 0", m_if.arready); end
    checks++; if ({s0_if.awvalid, s1_if.arvalid, def_if.wvalid, m_if.bvalid, m_if.rvalid} !== 5'b0) begin
      errors++; $display("FAIL rst_valids got %05b exp 00000", {s0_if.awvalid, s1_if.arvalid, def_if.wvalid, m_if.bvalid, m_if.rvalid}); end
    checks++; if (def_if.awaddr !== 32'h0 || def_if.wdata !== 32'h0) begin
      errors++; $display("FAIL rst_latched got %h/%h exp 0/0", def_if.awaddr, def_if.wdata); end
    idle_inputs();
    step();
    aresetn = 1'b1;
    #1;
    checks++; if (m_if.bvalid !== 1'b0 || m_if.rvalid !== 1'b0) begin
      errors++; $display("FAIL post_rst_resp got %0b%0b exp 00", m_if.bvalid, m_if.rvalid); end
  endtask

  task automatic test_write_s0();
    m_if.awvalid = 1; m_if.awaddr = 32'h0000_0010; m_if.awid = 1'b1;
    m_if.wvalid = 1; m_if.wdata = 32'h1234_5678; m_if.wstrb = 4'hF; m_if.bready = 1;
    #1;
    checks++; if (m_if.awready !== 1'b1 || m_if.wready !== 1'b1) begin
      errors++; $display("FAIL w_accept got %0b%0b exp 11", m_if.awready, m_if.wready); end
    step();
    m_if.awvalid = 0; m_if.wvalid = 0;
    s0_if.awready = 1; s0_if.wready = 1;
    #1;
    checks++; if (s0_if.awvalid !== 1'b1 || s0_if.wvalid !== 1'b1) begin
      errors++; $display("FAIL w_s0_valid got %0b%0b exp 11", s0_if.awvalid, s0_if.wvalid); end
    checks++; if (s0_if.awaddr !== 32'h10 || s0_if.wdata !== 32'h1234_5678 || s0_if.wstrb !== 4'hF || s0_if.awid !== 1'b1) begin
      errors++; $display("FAIL w_s0_payload got %h %h %h %0b exp 10 12345678 f 1", s0_if.awaddr, s0_if.wdata, s0_if.wstrb, s0_if.awid); end
    checks++; if (s1_if.awvalid !== 1'b0 || def_if.awvalid !== 1'b0) begin
      errors++; $display("FAIL w_other_awvalid got %0b%0b exp 00", s1_if.awvalid, def_if.awvalid); end
    step();
    s0_if.awready = 0; s0_if.wready = 0;
    s0_if.bvalid = 1; s0_if.bresp = 2'b00; s0_if.bid = 1'b1;
    #1;
    checks++; if (s0_if.awvalid !== 1'b0) begin errors++; $display("FAIL w_awvalid_drop got %0b exp 0", s0_if.awvalid); end
    checks++; if (m_if.bvalid !== 1'b1 || m_if.bresp !== 2'b00 || m_if.bid !== 1'b1 || s0_if.bready !== 1'b1) begin
      errors++; $display("FAIL w_bresp got v%0b r%0b id%0b br%0b exp v1 r0 id1 br1", m_if.bvalid, m_if.bresp, m_if.bid, s0_if.bready); end
    step();
    s0_if.bvalid = 0; m_if.bready = 0;
    #1;
    checks++; if (m_if.bvalid !== 1'b0) begin errors++; $display("FAIL w_bvalid_clear got %0b exp 0", m_if.bvalid); end
  endtask

  task automatic test_read_s1();
    m_if.arvalid = 1; m_if.araddr = 32'h0000_1004; m_if.arid = 1'b0; m_if.rready = 1;
    #1;
    checks++; if (m_if.arready !== 1'b1) begin errors++; $display("FAIL r_accept got %0b exp 1", m_if.arready); end
    step();
    m_if.arvalid = 0; s1_if.arready = 1;
    #1;
    checks++; if (s1_if.arvalid !== 1'b1 || s1_if.araddr !== 32'h1004 || s0_if.arvalid !== 1'b0) begin
      errors++; $display("FAIL r_s1_ar got v%0b a%h s0v%0b exp v1 a00001004 s0v0", s1_if.arvalid, s1_if.araddr, s0_if.arvalid); end
    step();
    s1_if.arready = 0; s1_if.rvalid = 1; s1_if.rdata = 32'hCAFE_0001; s1_if.rresp = 2'b00; s1_if.rlast = 0;
    #1;
    checks++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'hCAFE_0001 || m_if.rlast !== 1'b1 || s1_if.rready !== 1'b1) begin
      errors++; $display("FAIL r_s1_data got v%0b d%h l%0b rr%0b exp v1 dcafe0001 l1 rr1", m_if.rvalid, m_if.rdata, m_if.rlast, s1_if.rready); end
    step();
    s1_if.rvalid = 0; m_if.rready = 0;
    #1;
    checks++; if (m_if.rvalid !== 1'b0) begin errors++; $display("FAIL r_rvalid_clear got %0b exp 0", m_if.rvalid); end
  endtask

  task automatic test_read_default();
    int stray;
    stray = 0;
    s0_if.bvalid = 1;
    m_if.arvalid = 1; m_if.araddr = 32'h8000_0000; m_if.rready = 1;
    #1;
    checks++; if (m_if.bvalid !== 1'b0) begin errors++; $display("FAIL idle_bvalid_leak got %0b exp 0", m_if.bvalid); end
    step();
    s0_if.bvalid = 0;
    m_if.arvalid = 0; def_if.arready = 1;
    #1;
    stray += int'(s0_if.arvalid) + int'(s1_if.arvalid);
    checks++; if (def_if.arvalid !== 1'b1) begin errors++; $display("FAIL def_arvalid got %0b exp 1", def_if.arvalid); end
    step();
    def_if.arready = 0; def_if.rvalid = 1; def_if.rdata = 32'hBAAD_C0DE; def_if.rresp = 2'b00;
    s0_if.rvalid = 1; s0_if.rdata = 32'hDEAD_BEEF; s0_if.rresp = 2'b10;
    #1;
    stray += int'(s0_if.arvalid) + int'(s1_if.arvalid);
    checks++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'hBAAD_C0DE || m_if.rresp !== 2'b00) begin
      errors++; $display("FAIL def_rdata got v%0b d%h r%0d exp v1 dbaadc0de r0", m_if.rvalid, m_if.rdata, m_if.rresp); end
    checks++; if (s0_if.rready !== 1'b0) begin errors++; $display("FAIL def_s0_rready got %0b exp 0", s0_if.rready); end
    step();
    def_if.rvalid = 0; s0_if.rvalid = 0; m_if.rready = 0;
    #1;
    stray += int'(s0_if.arvalid) + int'(s1_if.arvalid);
    checks++; if (stray != 0) begin errors++; $display("FAIL def_stray_arvalid got %0d exp 0", stray); end
  endtask

  task automatic test_backpressure();
    int aw_cnt, w_cnt, b_cnt;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    m_if.awvalid = 1; m_if.awaddr = 32'h0000_0020; m_if.wvalid = 1; m_if.wdata = 32'hA5A5_0F0F; m_if.wstrb = 4'h3;
    step();
    m_if.awvalid = 0; m_if.wvalid = 0;
    s0_if.wready = 1;
    for (int c = 0; c < 8; c++) begin
      s0_if.awready = (c == 3);
      #1;
      aw_cnt += int'(s0_if.awvalid);
      w_cnt  += int'(s0_if.wvalid);
      step();
    end
    s0_if.awready = 0; s0_if.wready = 0;
    checks++; if (aw_cnt != 4) begin errors++; $display("FAIL bp_awvalid_cycles got %0d exp 4", aw_cnt); end
    checks++; if (w_cnt != 1) begin errors++; $display("FAIL bp_wvalid_cycles got %0d exp 1", w_cnt); end
    s0_if.bvalid = 1; m_if.bready = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      b_cnt += int'(m_if.bvalid);
      step();
    end
    s0_if.bvalid = 0; m_if.bready = 0;
    checks++; if (b_cnt != 1) begin errors++; $display("FAIL bp_bvalid_count got %0d exp 1", b_cnt); end
  endtask

  task automatic test_concurrent();
    int hold;
    hold = 0;
    m_if.awvalid = 1; m_if.awaddr = 32'h0000_0030; m_if.wvalid = 1; m_if.wdata = 32'h0000_00FF; m_if.wstrb = 4'h1;
    m_if.arvalid = 1; m_if.araddr = 32'h0000_1008; m_if.rready = 1; m_if.bready = 0;
    #1;
    checks++; if (m_if.awready !== 1'b1 || m_if.arready !== 1'b1) begin
      errors++; $display("FAIL cc_accept got aw%0b ar%0b exp aw1 ar1", m_if.awready, m_if.arready); end
    step();
    m_if.awvalid = 0; m_if.wvalid = 0; m_if.arvalid = 0;
    s0_if.awready = 1; s0_if.wready = 1; s1_if.arready = 1;
    #1;
    checks++; if (s0_if.awvalid !== 1'b1 || s1_if.arvalid !== 1'b1 || s1_if.awvalid !== 1'b0 || s0_if.arvalid !== 1'b0) begin
      errors++; $display("FAIL cc_fwd got s0aw%0b s1ar%0b s1aw%0b s0ar%0b exp 1100", s0_if.awvalid, s1_if.arvalid, s1_if.awvalid, s0_if.arvalid); end
    step();
    s0_if.awready = 0; s0_if.wready = 0; s1_if.arready = 0;
    s0_if.bvalid = 1; s0_if.bresp = 2'b00; s0_if.bid = 1'b0;
    s1_if.rvalid = 1; s1_if.rdata = 32'h5555_AAAA;
    #1;
    checks++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'h5555_AAAA) begin
      errors++; $display("FAIL cc_rdata got v%0b d%h exp v1 d5555aaaa", m_if.rvalid, m_if.rdata); end
    m_if.awvalid = 1; m_if.wvalid = 1; m_if.awaddr = 32'h0000_0040;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (m_if.bvalid === 1'b1 && s0_if.bready === 1'b0 && m_if.awready === 1'b0) hold++;
      step();
      s1_if.rvalid = 0;
    end
    checks++; if (hold != 5) begin errors++; $display("FAIL cc_bready_hold got %0d cycles exp 5", hold); end
    m_if.awvalid = 0; m_if.wvalid = 0; m_if.bready = 1;
    #1;
    checks++; if (m_if.bvalid !== 1'b1 || s0_if.bready !== 1'b1) begin
      errors++; $display("FAIL cc_b_release got v%0b br%0b exp 11", m_if.bvalid, s0_if.bready); end
    step();
    s0_if.bvalid = 0; m_if.bready = 0; m_if.rready = 0;
    #1;
    checks++; if (m_if.bvalid !== 1'b0 || m_if.rvalid !== 1'b0) begin
      errors++; $display("FAIL cc_done got b%0b r%0b exp 00", m_if.bvalid, m_if.rvalid); end
  endtask

  task automatic test_reset_mid();
    m_if.arvalid = 1; m_if.araddr = 32'h0000_1000; m_if.rready = 1;
    step();
    m_if.arvalid = 0;
    #1;
    checks++; if (s1_if.arvalid !== 1'b1) begin errors++; $display("FAIL mid_fwd got %0b exp 1", s1_if.arvalid); end
    #2;
    aresetn = 1'b0;
    #1;
    checks++; if (s1_if.arvalid !== 1'b0 || m_if.rvalid !== 1'b0) begin
      errors++; $display("FAIL mid_async_clear got ar%0b rv%0b exp 00", s1_if.arvalid, m_if.rvalid); end
    m_if.arvalid = 1; m_if.araddr = 32'h0000_1004;
    step();
    checks++; if (m_if.arready !== 1'b0) begin errors++; $display("FAIL mid_rst_arready got %0b exp 0", m_if.arready); end
    aresetn = 1'b1;
    #1;
    checks++; if (m_if.arready !== 1'b1 || s1_if.arvalid !== 1'b0) begin
      errors++; $display("FAIL mid_release got ar%0b s1v%0b exp 10", m_if.arready, s1_if.arvalid); end
    step();
    m_if.arvalid = 0; s1_if.arready = 1;
    #1;
    checks++; if (s1_if.arvalid !== 1'b1 || s1_if.araddr !== 32'h1004) begin
      errors++; $display("FAIL mid_refwd got v%0b a%h exp v1 a00001004", s1_if.arvalid, s1_if.araddr); end
    step();
    s1_if.arready = 0; s1_if.rvalid = 1; s1_if.rdata = 32'h0BAD_F00D;
    #1;
    checks++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL mid_rdata got v%0b d%h exp v1 d0badf00d", m_if.rvalid, m_if.rdata); end
    step();
    s1_if.rvalid = 0; m_if.rready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_s0();
    test_read_s1();
    test_read_default();
    test_backpressure();
    test_concurrent();
    test_reset_mid();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
